// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - shared types, register offsets and helpers for the ECC controller
package ecc_pkg;

   // APB register offsets (zero-extended to the bus address width on compare)
   localparam logic [7:0] REG_CTRL      = 8'h00;
   localparam logic [7:0] REG_DATA_IN   = 8'h04;
   localparam logic [7:0] REG_CW_WIDTH  = 8'h08;
   localparam logic [7:0] REG_NOISE     = 8'h0C;
   localparam logic [7:0] REG_STATUS    = 8'h10;

   typedef enum logic [1:0] {
      ENCODE = 2'd0,
      DECODE = 2'd1,
      FULL   = 2'd2,
      RSVD   = 2'd3
   } ctrl_op_e;

   typedef enum logic [1:0] {
      CW_8  = 2'd0,
      CW_16 = 2'd1,
      CW_32 = 2'd2
   } cw_width_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ENC_RUN = 3'd1,
      ST_NOISE   = 3'd2,
      ST_DEC_RUN = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

   // Parity-check row coverage masks shared with the encoder/decoder datapath
   localparam logic [31:0] H_P1  = 32'h5555_5555;
   localparam logic [31:0] H_P2  = 32'h6666_6666;
   localparam logic [31:0] H_P4  = 32'h7878_7878;
   localparam logic [31:0] H_P8  = 32'h7F80_7F80;
   localparam logic [31:0] H_P16 = 32'h7FFF_8000;

   // Low-bit mask for a codeword width; the unused code 3 behaves as 32 bits
   function automatic logic [31:0] cw_mask(input logic [1:0] w);
      case (w)
         2'd0:    cw_mask = 32'h0000_00FF;
         2'd1:    cw_mask = 32'h0000_FFFF;
         default: cw_mask = 32'hFFFF_FFFF;
      endcase
   endfunction

endpackage

// File: rtl/ecc_apb_regs.sv
// rtl/ecc_apb_regs.sv - APB decode, register storage and read data for the ECC controller
module ecc_apb_regs
   import ecc_pkg::*;
#(
   parameter int AMBA_WORD       = 32,
   parameter int AMBA_ADDR_WIDTH = 20,
   parameter int DATA_WIDTH      = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [AMBA_ADDR_WIDTH-1:0] paddr,
   input  logic                       psel,
   input  logic                       penable,
   input  logic                       pwrite,
   input  logic [AMBA_WORD-1:0]       pwdata,
   output logic [AMBA_WORD-1:0]       prdata,
   input  logic                       busy_i,
   input  logic [1:0]                 last_err_i,
   output logic                       start_o,
   output ctrl_op_e                   start_op_o,
   output cw_width_e                  width_o,
   output logic [DATA_WIDTH-1:0]      data_o,
   output logic [DATA_WIDTH-1:0]      noise_o
);

   ctrl_op_e              ctrl_q,   ctrl_d;
   cw_width_e             width_q,  width_d;
   logic [DATA_WIDTH-1:0] data_q,   data_d;
   logic [DATA_WIDTH-1:0] noise_q,  noise_d;
   logic [AMBA_WORD-1:0]  prdata_q, prdata_d;

   logic wr_en;
   logic rd_setup;

   assign wr_en      = psel & penable & pwrite;
   assign rd_setup   = psel & ~penable & ~pwrite;
   assign start_op_o = ctrl_op_e'(pwdata[1:0]);

   // Register writes (locked while busy), start detection and setup-phase read capture
   always_comb begin
      ctrl_d   = ctrl_q;
      width_d  = width_q;
      data_d   = data_q;
      noise_d  = noise_q;
      prdata_d = prdata_q;
      start_o  = 1'b0;
      if (wr_en && !busy_i) begin
         case (paddr)
            AMBA_ADDR_WIDTH'(REG_CTRL): begin
               ctrl_d  = ctrl_op_e'(pwdata[1:0]);
               start_o = (pwdata[1:0] != 2'd3);
            end
            AMBA_ADDR_WIDTH'(REG_DATA_IN):  data_d  = DATA_WIDTH'(pwdata);
            AMBA_ADDR_WIDTH'(REG_CW_WIDTH): width_d = (pwdata[1:0] == 2'd3) ? CW_32
                                                      : cw_width_e'(pwdata[1:0]);
            AMBA_ADDR_WIDTH'(REG_NOISE):    noise_d = DATA_WIDTH'(pwdata);
            default: ;
         endcase
      end
      if (rd_setup) begin
         case (paddr)
            AMBA_ADDR_WIDTH'(REG_CTRL):     prdata_d = AMBA_WORD'(ctrl_q);
            AMBA_ADDR_WIDTH'(REG_DATA_IN):  prdata_d = AMBA_WORD'(data_q);
            AMBA_ADDR_WIDTH'(REG_CW_WIDTH): prdata_d = AMBA_WORD'(width_q);
            AMBA_ADDR_WIDTH'(REG_NOISE):    prdata_d = AMBA_WORD'(noise_q);
            AMBA_ADDR_WIDTH'(REG_STATUS):   prdata_d = AMBA_WORD'({last_err_i, busy_i});
            default:                        prdata_d = '0;
         endcase
      end
   end

   // Register state
   always_ff @(posedge clk) begin
      if (!rst) begin
         ctrl_q   <= ENCODE;
         width_q  <= CW_8;
         data_q   <= '0;
         noise_q  <= '0;
         prdata_q <= '0;
      end else begin
         ctrl_q   <= ctrl_d;
         width_q  <= width_d;
         data_q   <= data_d;
         noise_q  <= noise_d;
         prdata_q <= prdata_d;
      end
   end

   assign prdata  = prdata_q;
   assign width_o = width_q;
   assign data_o  = data_q;
   assign noise_o = noise_q;

endmodule

// File: rtl/ecc_op_ctrl.sv
// rtl/ecc_op_ctrl.sv - operation FSM sequencing encode/decode/full-channel datapath passes
module ecc_op_ctrl
   import ecc_pkg::*;
#(
   parameter int AMBA_WORD       = 32,
   parameter int AMBA_ADDR_WIDTH = 20,
   parameter int DATA_WIDTH      = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
   input  logic                       PSEL,
   input  logic                       PENABLE,
   input  logic                       PWRITE,
   input  logic [AMBA_WORD-1:0]       PWDATA,
   output logic [AMBA_WORD-1:0]       PRDATA,
   output logic                       dp_start,
   output logic                       dp_mode,
   output logic [1:0]                 dp_width,
   output logic [DATA_WIDTH-1:0]      dp_data_in,
   input  logic                       dp_valid,
   input  logic [DATA_WIDTH-1:0]      dp_data_out,
   input  logic [1:0]                 dp_num_err,
   output logic [DATA_WIDTH-1:0]      data_out,
   output logic                       operation_done,
   output logic [1:0]                 num_of_errors
);

   logic                  start;
   ctrl_op_e              start_op;
   cw_width_e             reg_width;
   logic [DATA_WIDTH-1:0] reg_data;
   logic [DATA_WIDTH-1:0] reg_noise;
   logic [DATA_WIDTH-1:0] mask;
   logic                  busy;
   logic                  pass_done;

   state_e                state_q,      state_d;
   ctrl_op_e              op_q,         op_d;
   logic [DATA_WIDTH-1:0] enc_q,        enc_d;
   logic                  dp_start_q,   dp_start_d;
   logic                  dp_mode_q,    dp_mode_d;
   logic [1:0]            dp_width_q,   dp_width_d;
   logic [DATA_WIDTH-1:0] dp_data_in_q, dp_data_in_d;
   logic [DATA_WIDTH-1:0] data_out_q,   data_out_d;
   logic                  op_done_q,    op_done_d;
   logic [1:0]            num_err_q,    num_err_d;

   ecc_apb_regs #(
      .AMBA_WORD       (AMBA_WORD),
      .AMBA_ADDR_WIDTH (AMBA_ADDR_WIDTH),
      .DATA_WIDTH      (DATA_WIDTH)
   ) u_regs (
      .clk        (clk),
      .rst        (rst),
      .paddr      (PADDR),
      .psel       (PSEL),
      .penable    (PENABLE),
      .pwrite     (PWRITE),
      .pwdata     (PWDATA),
      .prdata     (PRDATA),
      .busy_i     (busy),
      .last_err_i (num_err_q),
      .start_o    (start),
      .start_op_o (start_op),
      .width_o    (reg_width),
      .data_o     (reg_data),
      .noise_o    (reg_noise)
   );

   assign busy = (state_q != ST_IDLE);
   assign mask = DATA_WIDTH'(cw_mask(reg_width));
   // A valid coincident with the launch pulse belongs to no pass of ours
   assign pass_done = dp_valid & ~dp_start_q;

   // Next-state and output-register computation for the operation sequence
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      enc_d        = enc_q;
      dp_start_d   = 1'b0;
      dp_mode_d    = dp_mode_q;
      dp_width_d   = dp_width_q;
      dp_data_in_d = dp_data_in_q;
      data_out_d   = data_out_q;
      op_done_d    = 1'b0;
      num_err_d    = num_err_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               op_d         = start_op;
               dp_start_d   = 1'b1;
               dp_width_d   = reg_width;
               dp_data_in_d = reg_data & mask;
               dp_mode_d    = (start_op == DECODE);
               state_d      = (start_op == DECODE) ? ST_DEC_RUN : ST_ENC_RUN;
            end
         end
         ST_ENC_RUN: begin
            if (pass_done) begin
               if (op_q == FULL) begin
                  enc_d   = dp_data_out & mask;
                  state_d = ST_NOISE;
               end else begin
                  data_out_d = dp_data_out & mask;
                  num_err_d  = 2'd0;
                  op_done_d  = 1'b1;
                  state_d    = ST_DONE;
               end
            end
         end
         ST_NOISE: begin
            dp_start_d   = 1'b1;
            dp_mode_d    = 1'b1;
            dp_data_in_d = enc_q ^ (reg_noise & mask);
            state_d      = ST_DEC_RUN;
         end
         ST_DEC_RUN: begin
            if (pass_done) begin
               data_out_d = dp_data_out & mask;
               num_err_d  = dp_num_err;
               op_done_d  = 1'b1;
               state_d    = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM and registered datapath/result outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         op_q         <= ENCODE;
         enc_q        <= '0;
         dp_start_q   <= 1'b0;
         dp_mode_q    <= 1'b0;
         dp_width_q   <= 2'd0;
         dp_data_in_q <= '0;
         data_out_q   <= '0;
         op_done_q    <= 1'b0;
         num_err_q    <= 2'd0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         enc_q        <= enc_d;
         dp_start_q   <= dp_start_d;
         dp_mode_q    <= dp_mode_d;
         dp_width_q   <= dp_width_d;
         dp_data_in_q <= dp_data_in_d;
         data_out_q   <= data_out_d;
         op_done_q    <= op_done_d;
         num_err_q    <= num_err_d;
      end
   end

   assign dp_start       = dp_start_q;
   assign dp_mode        = dp_mode_q;
   assign dp_width       = dp_width_q;
   assign dp_data_in     = dp_data_in_q;
   assign data_out       = data_out_q;
   assign operation_done = op_done_q;
   assign num_of_errors  = num_err_q;

endmodule

// File: tb/tb_ecc_op_ctrl.sv
// tb/tb_ecc_op_ctrl.sv - scoreboard bench for the ECC operation controller
module tb_ecc_op_ctrl;

   typedef struct packed {
      logic        mode;
      logic [1:0]  width;
      logic [31:0] data;
   } start_t;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  err;
   } done_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [19:0] PADDR;
   logic        PSEL, PENABLE, PWRITE;
   logic [31:0] PWDATA, PRDATA;
   logic        dp_start, dp_mode;
   logic [1:0]  dp_width;
   logic [31:0] dp_data_in;
   logic        dp_valid;
   logic [31:0] dp_data_out;
   logic [1:0]  dp_num_err;
   logic [31:0] data_out;
   logic        operation_done;
   logic [1:0]  num_of_errors;

   start_t exp_start[$];
   done_t  exp_done[$];
   int     vectors    = 0;
   int     miscompares = 0;
   logic [31:0] rd;

   ecc_op_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .PADDR          (PADDR),
      .PSEL           (PSEL),
      .PENABLE        (PENABLE),
      .PWRITE         (PWRITE),
      .PWDATA         (PWDATA),
      .PRDATA         (PRDATA),
      .dp_start       (dp_start),
      .dp_mode        (dp_mode),
      .dp_width       (dp_width),
      .dp_data_in     (dp_data_in),
      .dp_valid       (dp_valid),
      .dp_data_out    (dp_data_out),
      .dp_num_err     (dp_num_err),
      .data_out       (data_out),
      .operation_done (operation_done),
      .num_of_errors  (num_of_errors)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
      end
   endtask

   task automatic apb_write(input logic [19:0] addr, input logic [31:0] data);
      @(posedge clk) #1;
      PADDR = addr; PWDATA = data; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
      @(posedge clk) #1;
      PENABLE = 1'b1;
      @(posedge clk) #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [19:0] addr, output logic [31:0] data);
      @(posedge clk) #1;
      PADDR = addr; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
      @(posedge clk) #1;
      PENABLE = 1'b1;
      data = PRDATA;
      @(posedge clk) #1;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic wait_start();
      int n = 0;
      while (!dp_start && n < 50) begin
         @(posedge clk) #1;
         n++;
      end
      check("dp_start_seen", {31'd0, dp_start}, 32'd1);
   endtask

   task automatic pulse_valid(input int dly, input logic [31:0] d, input logic [1:0] e,
                              input logic exp_done_now);
      repeat (dly) @(posedge clk) #1;
      dp_valid = 1'b1; dp_data_out = d; dp_num_err = e;
      @(posedge clk) #1;
      dp_valid = 1'b0;
      check("done_latency", {31'd0, operation_done}, {31'd0, exp_done_now});
   endtask

   // Monitor: every datapath launch and every completion must match the queued expectation
   initial begin
      start_t s;
      done_t  d;
      forever begin
         @(negedge clk);
         if (dp_start === 1'b1) begin
            if (exp_start.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL unexpected_dp_start: got pulse, required none");
            end else begin
               s = exp_start.pop_front();
               check("dp_mode",    {31'd0, dp_mode},  {31'd0, s.mode});
               check("dp_width",   {30'd0, dp_width}, {30'd0, s.width});
               check("dp_data_in", dp_data_in,        s.data);
            end
         end
         if (operation_done === 1'b1) begin
            if (exp_done.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL unexpected_operation_done: got pulse, required none");
            end else begin
               d = exp_done.pop_front();
               check("data_out",      data_out,                d.data);
               check("num_of_errors", {30'd0, num_of_errors}, {30'd0, d.err});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; PADDR = '0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PWDATA = '0;
      dp_valid = 1'b0; dp_data_out = '0; dp_num_err = '0;

      // Reset with random APB traffic
      repeat (2) begin
         @(posedge clk) #1;
         PSEL = 1'($urandom_range(0, 1)); PENABLE = 1'($urandom_range(0, 1));
         PWRITE = 1'($urandom_range(0, 1)); PADDR = 20'($urandom_range(0, 4) * 4);
         PWDATA = $urandom;
      end
      @(negedge clk);
      check("rst_prdata",     PRDATA, 32'd0);
      check("rst_data_out",   data_out, 32'd0);
      check("rst_op_done",    {31'd0, operation_done}, 32'd0);
      check("rst_num_err",    {30'd0, num_of_errors}, 32'd0);
      check("rst_dp_start",   {31'd0, dp_start}, 32'd0);
      check("rst_dp_mode",    {31'd0, dp_mode}, 32'd0);
      check("rst_dp_width",   {30'd0, dp_width}, 32'd0);
      check("rst_dp_data_in", dp_data_in, 32'd0);
      @(posedge clk) #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; rst = 1'b1;
      apb_read(20'h10, rd); check("rst_status", rd, 32'h0);

      // Encode, 8-bit; a valid coincident with dp_start must be ignored
      apb_write(20'h08, 32'd0);
      apb_write(20'h04, 32'h5);
      exp_start.push_back('{mode: 1'b0, width: 2'd0, data: 32'h05});
      apb_write(20'h00, 32'd0);
      wait_start();
      dp_valid = 1'b1; dp_data_out = 32'hDEAD; dp_num_err = 2'd2;
      @(posedge clk) #1;
      dp_valid = 1'b0;
      exp_done.push_back('{data: 32'hB5, err: 2'd0});
      pulse_valid(3, 32'hB5, 2'd1, 1'b1);

      // Full channel, 16-bit
      apb_write(20'h08, 32'd1);
      apb_write(20'h04, 32'h7FF);
      apb_write(20'h0C, 32'h0004);
      exp_start.push_back('{mode: 1'b0, width: 2'd1, data: 32'h07FF});
      apb_write(20'h00, 32'd2);
      wait_start();
      exp_start.push_back('{mode: 1'b1, width: 2'd1, data: 32'hFFFB});
      pulse_valid(2, 32'h0000FFFF, 2'd0, 1'b0);
      wait_start();
      exp_done.push_back('{data: 32'h07FF, err: 2'd1});
      pulse_valid(4, 32'hFFFF07FF, 2'd1, 1'b1);

      // Busy lockout during ENC_RUN, 32-bit
      apb_write(20'h08, 32'd2);
      apb_write(20'h04, 32'h00C0FFEE);
      exp_start.push_back('{mode: 1'b0, width: 2'd2, data: 32'h00C0FFEE});
      apb_write(20'h00, 32'd0);
      wait_start();
      apb_write(20'h04, 32'h1234);
      apb_write(20'h00, 32'd1);
      apb_read(20'h04, rd); check("busy_data_in_kept", rd, 32'h00C0FFEE);
      apb_read(20'h10, rd); check("busy_status", rd, 32'h3);
      exp_done.push_back('{data: 32'h12345678, err: 2'd0});
      pulse_valid(1, 32'h12345678, 2'd3, 1'b1);
      repeat (3) @(posedge clk) #1;
      apb_read(20'h10, rd); check("idle_status", rd, 32'h0);
      apb_read(20'h00, rd); check("busy_ctrl_kept", rd, 32'h0);

      // Operand masking and reserved encodings
      apb_write(20'h08, 32'd0);
      apb_write(20'h04, 32'hFFFFFFFF);
      exp_start.push_back('{mode: 1'b1, width: 2'd0, data: 32'h000000FF});
      apb_write(20'h00, 32'd1);
      wait_start();
      exp_done.push_back('{data: 32'h12, err: 2'd2});
      pulse_valid(2, 32'h12, 2'd2, 1'b1);
      apb_write(20'h00, 32'd3);
      repeat (10) @(posedge clk) #1;
      apb_read(20'h00, rd); check("ctrl_rsvd_stored", rd, 32'h3);
      apb_write(20'h14, 32'hFFFF);
      apb_read(20'h14, rd); check("unmapped_read", rd, 32'h0);
      apb_write(20'h08, 32'd3);
      apb_read(20'h08, rd); check("width3_as_2", rd, 32'h2);
      apb_read(20'h10, rd); check("status_last_err", rd, 32'h4);

      // Reset mid-operation during DEC_RUN
      exp_start.push_back('{mode: 1'b1, width: 2'd2, data: 32'h1});
      apb_write(20'h04, 32'h1);
      apb_write(20'h00, 32'd1);
      wait_start();
      repeat (2) @(posedge clk) #1;
      rst = 1'b0;
      repeat (2) @(posedge clk) #1;
      rst = 1'b1;
      pulse_valid(1, 32'h55, 2'd1, 1'b0);
      repeat (5) @(posedge clk) #1;
      check("midrst_data_out", data_out, 32'h0);
      check("midrst_num_err", {30'd0, num_of_errors}, 32'h0);
      apb_read(20'h10, rd); check("midrst_status", rd, 32'h0);

      check("start_queue_empty", exp_start.size(), 32'd0);
      check("done_queue_empty",  exp_done.size(),  32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ecc_op_ctrl.md
Name: ecc_op_ctrl

Overview:
APB-facing controller for the ECC encoder/decoder datapath. Holds the register file (CTRL, DATA_IN, CODEWORD_WIDTH, NOISE) and runs an operation FSM. The FSM sequences the datapath through encode, decode or full-channel (encode, noise injection, decode) passes and returns data_out, num_of_errors and a one-cycle operation_done to the top level.

Parameters:
AMBA_WORD, 32, APB data width
AMBA_ADDR_WIDTH, 20, APB address width
DATA_WIDTH, 32, widest codeword (datapath port width)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset
PADDR  in  AMBA_ADDR_WIDTH  APB address
PSEL  in  1  APB select
PENABLE  in  1  APB access phase
PWRITE  in  1  APB write
PWDATA  in  AMBA_WORD  APB write data
PRDATA  out  AMBA_WORD  APB read data
dp_start  out  1  one-cycle pulse, launch datapath pass
dp_mode  out  1  0 encode, 1 decode
dp_width  out  2  0=8b, 1=16b, 2=32b codeword
dp_data_in  out  DATA_WIDTH  datapath operand
dp_valid  in  1  one-cycle pulse, pass complete
dp_data_out  in  DATA_WIDTH  datapath result
dp_num_err  in  2  decoder error count (0,1,2=uncorrectable)
data_out  out  DATA_WIDTH  final result
operation_done  out  1  one-cycle completion pulse
num_of_errors  out  2  final error count

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-low. Reset clears all registers, returns the FSM to IDLE and zeroes PRDATA, data_out, operation_done, num_of_errors, dp_start, dp_mode, dp_width and dp_data_in.
- Register map (PADDR, full compare):
  - 0x00 CTRL[1:0]: 0 encode, 1 decode, 2 full channel, 3 reserved.
  - 0x04 DATA_IN.
  - 0x08 CODEWORD_WIDTH[1:0]: value 3 treated as 2.
  - 0x0C NOISE.
  - 0x10 STATUS (read-only): bit0 busy, bits2:1 last num_of_errors.
  - Other addresses read 0; writes to them are ignored.
- Write: sampled on the clk edge with PSEL&PENABLE&PWRITE. No wait states.
- Read: PRDATA loaded on the setup-phase edge (PSEL&!PENABLE&!PWRITE) and held through the access phase. Reserved bits read 0.
- A CTRL write in IDLE with value 0–2 starts an operation on the same edge. CTRL value 3 stores the value but starts nothing.
- While busy (FSM not IDLE), writes to CTRL, DATA_IN, CODEWORD_WIDTH and NOISE are ignored. Reads stay functional.
- Operand masking: DATA_IN and NOISE are masked to the codeword width (8/16/32 LSBs) before use.
- FSM states: IDLE, ENC_RUN, NOISE, DEC_RUN, DONE.
  - encode: IDLE -> ENC_RUN -> DONE.
  - decode: IDLE -> DEC_RUN -> DONE.
  - full: IDLE -> ENC_RUN -> NOISE -> DEC_RUN -> DONE.
- ENC_RUN / DEC_RUN: dp_start pulses on the first cycle in the state, with dp_mode, dp_width and dp_data_in stable for the whole state. The FSM waits for dp_valid, which has unbounded latency. A dp_valid arriving on the same cycle as dp_start is ignored.
- NOISE: one cycle. The stored encoder result is XORed with the masked NOISE and becomes the decode operand.
- DONE: one cycle.
  - operation_done=1.
  - data_out = last dp_data_out, masked.
  - num_of_errors = dp_num_err for decode/full, 0 for encode.
  - data_out and num_of_errors hold until the next DONE.
- Latency: operation_done rises exactly 1 cycle after the final dp_valid. A CTRL write to dp_start takes 1 cycle.
- dp_valid outside ENC_RUN/DEC_RUN is ignored.
- Reset mid-operation aborts the pass and does not produce operation_done.

Decomposition:
- Package ecc_pkg holds:
  - register offset localparams;
  - ctrl_op_e enum (ENCODE, DECODE, FULL, RSVD);
  - cw_width_e enum;
  - state_e enum;
  - width-to-mask function;
  - H matrix constants.
- One natural sub-module, ecc_apb_regs: APB decode, register storage and PRDATA. It exposes start/op/width/data/noise to the FSM in ecc_op_ctrl.

Test Plan:
- Reset: rst=0 for 2 cycles with random APB traffic -> all outputs 0, STATUS reads 0x0.
- Encode: write WIDTH=0, DATA_IN=0x5, CTRL=0; datapath model returns 0xB5 after 3 cycles -> single dp_start with dp_mode=0, dp_width=0, dp_data_in=0x05. Then operation_done 1 cycle after dp_valid, data_out=0xB5, num_of_errors=0.
- Full channel: WIDTH=1, DATA_IN=0x7FF, NOISE=0x0004, CTRL=2; encoder returns 0xFFFF -> second dp_start has dp_mode=1 and dp_data_in=0xFFFB. Decoder returns 0x7FF with err 1 -> data_out=0x7FF, num_of_errors=1, exactly one operation_done.
- Busy lockout: during ENC_RUN write DATA_IN=0x1234 and CTRL=1 -> DATA_IN readback unchanged, no second operation. STATUS bit0=1 during the operation and 0 after.
- Masking and reserved: WIDTH=0, DATA_IN=0xFFFFFFFF, CTRL=1 -> dp_data_in=0x000000FF. Then CTRL=3 -> no dp_start, no operation_done. Read 0x14 -> 0.
- Reset mid-op: rst low during DEC_RUN, then dp_valid pulses -> no operation_done, FSM in IDLE, data_out=0.
